// File: rtl/cam_capture_stream.sv
// DVP camera capture front end: byte-to-pixel assembly, line-based frame-buffer
// addressing, frame geometry checking and frame counting. Macro CAP_DECIMATE_EN adds 2x2 decimation.
module cam_capture_stream #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int BPP        = 2,
  parameter int ADDR_W     = 19,
  parameter int SWAP_BYTES = 0
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  input  logic              cap_en,
`ifdef CAP_DECIMATE_EN
  input  logic              decim,
`endif
  output logic [ADDR_W-1:0] addr,
  output logic [15:0]       dout,
  output logic              we,
  output logic              end_of_frame,
  output logic              frame_err,
  output logic [7:0]        frame_count
);

  localparam int XW  = $clog2(H_ACTIVE + 2);
  localparam int YW  = $clog2(V_ACTIVE + 2);
  localparam int LBW = ADDR_W + 1;
  localparam logic [XW-1:0] X_FULL = XW'(H_ACTIVE);
  localparam logic [XW-1:0] X_SAT  = XW'(H_ACTIVE + 1);
  localparam logic [YW-1:0] Y_FULL = YW'(V_ACTIVE);
  localparam logic [YW-1:0] Y_SAT  = YW'(V_ACTIVE + 1);

  typedef enum logic {IDLE, FRAME} state_e;

  state_e            state_q, state_d;
  logic              vs_r1_q, vs_r2_q, href_r1_q, href_r2_q;
  logic [7:0]        d_r_q, first_q, first_d;
  logic              phase_q, phase_d, err_q, err_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [LBW-1:0]    lb_q, lb_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       dout_q, dout_d;
  logic              we_q, we_d, eof_q, eof_d, ferr_q, ferr_d;
  logic [7:0]        fcnt_q, fcnt_d;
  logic              vs_rise, href_rise, href_fall;
  logic              cur_phase, pix_done, wr_ok;
  logic [15:0]       pixel;
  logic [ADDR_W-1:0] pix_addr;
`ifdef CAP_DECIMATE_EN
  logic              decim_q, decim_d;
`endif

  assign vs_rise   = vs_r1_q & ~vs_r2_q;
  assign href_rise = href_r1_q & ~href_r2_q;
  assign href_fall = ~href_r1_q & href_r2_q;

  // Capture enable only takes effect at a frame boundary.
  always_comb begin
    state_d = state_q;
    if (vs_rise) state_d = cap_en ? FRAME : IDLE;
  end

`ifdef CAP_DECIMATE_EN
  assign wr_ok    = ~decim_q | (~x_q[0] & ~y_q[0]);
  assign pix_addr = decim_q ? ADDR_W'((int'(y_q) >> 1) * (H_ACTIVE / 2) + (int'(x_q) >> 1))
                            : ADDR_W'(lb_q + LBW'(x_q));
`else
  assign wr_ok    = 1'b1;
  assign pix_addr = ADDR_W'(lb_q + LBW'(x_q));
`endif

  // NOTE: every variable gets a default before any branch, so no path infers a latch.
  always_comb begin
    x_d = x_q; y_d = y_q; lb_d = lb_q; phase_d = phase_q; first_d = first_q; err_d = err_q;
    addr_d = addr_q; dout_d = dout_q; fcnt_d = fcnt_q;
    we_d = 1'b0; eof_d = 1'b0; ferr_d = 1'b0;
    cur_phase = 1'b0; pix_done = 1'b0; pixel = 16'h0000;
`ifdef CAP_DECIMATE_EN
    decim_d = decim_q;
`endif
    if (vs_rise) begin
      // Frame close wins over any line end landing on the same cycle.
      if (state_q == FRAME) begin
        eof_d  = 1'b1;
        ferr_d = err_q | (y_q != Y_FULL);
        fcnt_d = fcnt_q + 8'd1;
      end
      x_d = '0; y_d = '0; lb_d = '0; phase_d = 1'b0; addr_d = '0; err_d = 1'b0;
`ifdef CAP_DECIMATE_EN
      decim_d = decim;
`endif
    end else if (state_q == FRAME) begin
      if (href_r1_q) begin
        cur_phase = href_rise ? 1'b0 : phase_q;
        phase_d   = ~cur_phase;
        if (BPP == 1) begin
          pix_done = 1'b1;
          pixel    = {8'h00, d_r_q};
        end else if (!cur_phase) begin
          first_d = d_r_q;
        end else begin
          pix_done = 1'b1;
          pixel    = (SWAP_BYTES != 0) ? {d_r_q, first_q} : {first_q, d_r_q};
        end
        if (pix_done) begin
          if (x_q < X_FULL && y_q < Y_FULL && wr_ok) begin
            we_d   = 1'b1;
            addr_d = pix_addr;
            dout_d = pixel;
          end
          if (x_q != X_SAT) x_d = x_q + 1'b1;
        end
      end else if (href_fall) begin
        if (x_q != '0) begin
          if (x_q != X_FULL) err_d = 1'b1;
          if (y_q != Y_SAT) y_d = y_q + 1'b1;
          // Past the last line the base is never used, so stop it short of overflowing.
          if (y_q < Y_FULL) lb_d = lb_q + LBW'(H_ACTIVE);
          x_d = '0;
        end
        if (BPP == 2 && phase_q) err_d = 1'b1;
      end
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      // NOTE: the input sync stages are cleared too, so a reset cannot leave a stale edge behind.
      state_q <= IDLE;
      vs_r1_q <= 1'b0; vs_r2_q <= 1'b0; href_r1_q <= 1'b0; href_r2_q <= 1'b0; d_r_q <= 8'h00;
      x_q <= '0; y_q <= '0; lb_q <= '0; phase_q <= 1'b0; first_q <= 8'h00; err_q <= 1'b0;
      addr_q <= '0; dout_q <= 16'h0000; we_q <= 1'b0; eof_q <= 1'b0; ferr_q <= 1'b0;
      fcnt_q <= 8'h00;
`ifdef CAP_DECIMATE_EN
      decim_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      vs_r1_q <= vsync; vs_r2_q <= vs_r1_q; href_r1_q <= href; href_r2_q <= href_r1_q; d_r_q <= d;
      x_q <= x_d; y_q <= y_d; lb_q <= lb_d; phase_q <= phase_d; first_q <= first_d; err_q <= err_d;
      addr_q <= addr_d; dout_q <= dout_d; we_q <= we_d; eof_q <= eof_d; ferr_q <= ferr_d;
      fcnt_q <= fcnt_d;
`ifdef CAP_DECIMATE_EN
      decim_q <= decim_d;
`endif
    end
  end

  assign addr         = addr_q;
  assign dout         = dout_q;
  assign we           = we_q;
  assign end_of_frame = eof_q;
  assign frame_err    = ferr_q;
  assign frame_count  = fcnt_q;

endmodule

// File: tb/tb_cam_capture_stream.sv
// Bench for cam_capture_stream: three variants (BPP=2, BPP=2 swapped, BPP=1) share one stimulus;
// a transaction-level model predicts writes and frame-close pulses with their cycle of arrival.
module tb_cam_capture_stream;
  localparam int H = 4;
  localparam int V = 2;
  localparam int NI = 3;

  typedef struct { int cyc; int addr; logic [15:0] dout; } wr_t;
  typedef struct { int cyc; bit err; int cnt; } eof_t;

  logic       pclk, rst_n, vsync, href, cap_en;
  logic [7:0] d;
  logic [2:0]  addr_w [NI];
  logic [15:0] dout_w [NI];
  logic        we_w   [NI];
  logic        eof_w  [NI];
  logic        ferr_w [NI];
  logic [7:0]  fcnt_w [NI];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit cmp_on = 0;

  wr_t  exp_wr  [NI][$];
  eof_t exp_eof [NI][$];
  wr_t  obs_wr  [NI][$];
  eof_t obs_eof [NI][$];

  bit         m_cap [NI];
  bit         m_err [NI];
  bit         m_half[NI];
  int         m_x   [NI];
  int         m_y   [NI];
  int         m_cnt [NI];
  logic [7:0] m_first[NI];

  cam_capture_stream #(.H_ACTIVE(H), .V_ACTIVE(V), .BPP(2), .ADDR_W(3), .SWAP_BYTES(0)) u_dut (
    .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .d(d), .cap_en(cap_en),
    .addr(addr_w[0]), .dout(dout_w[0]), .we(we_w[0]), .end_of_frame(eof_w[0]),
    .frame_err(ferr_w[0]), .frame_count(fcnt_w[0]));

  cam_capture_stream #(.H_ACTIVE(H), .V_ACTIVE(V), .BPP(2), .ADDR_W(3), .SWAP_BYTES(1)) u_swap (
    .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .d(d), .cap_en(cap_en),
    .addr(addr_w[1]), .dout(dout_w[1]), .we(we_w[1]), .end_of_frame(eof_w[1]),
    .frame_err(ferr_w[1]), .frame_count(fcnt_w[1]));

  cam_capture_stream #(.H_ACTIVE(H), .V_ACTIVE(V), .BPP(1), .ADDR_W(3), .SWAP_BYTES(0)) u_bpp1 (
    .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .d(d), .cap_en(cap_en),
    .addr(addr_w[2]), .dout(dout_w[2]), .we(we_w[2]), .end_of_frame(eof_w[2]),
    .frame_err(ferr_w[2]), .frame_count(fcnt_w[2]));

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  function automatic int bpp_of(input int i);
    return (i == 2) ? 1 : 2;
  endfunction

  task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d cyc=%0d got=%0h want=%0h", name, inst, cyc, act, exp);
    end
  endtask

  // Model: a byte driven at cycle c that completes a pixel shows up as a write at c+2.
  task automatic model_byte(input logic [7:0] b, input int c);
    for (int i = 0; i < NI; i++) begin
      if (m_cap[i]) begin
        logic [15:0] px;
        bit done;
        wr_t w;
        done = 0;
        px = 16'h0000;
        if (bpp_of(i) == 1) begin
          px = {8'h00, b}; done = 1;
        end else if (!m_half[i]) begin
          m_first[i] = b; m_half[i] = 1;
        end else begin
          px = (i == 1) ? {b, m_first[i]} : {m_first[i], b};
          m_half[i] = 0; done = 1;
        end
        if (done) begin
          if (m_x[i] < H && m_y[i] < V) begin
            w.cyc = c + 2; w.addr = m_y[i] * H + m_x[i]; w.dout = px;
            exp_wr[i].push_back(w);
          end
          if (m_x[i] < H + 1) m_x[i]++;
        end
      end
    end
  endtask

  task automatic model_line_end();
    for (int i = 0; i < NI; i++) begin
      if (m_cap[i]) begin
        if (bpp_of(i) == 2 && m_half[i]) m_err[i] = 1;
        m_half[i] = 0;
        if (m_x[i] != 0) begin
          if (m_x[i] != H) m_err[i] = 1;
          if (m_y[i] < V + 1) m_y[i]++;
          m_x[i] = 0;
        end
      end
    end
  endtask

  task automatic model_vsync(input int c);
    for (int i = 0; i < NI; i++) begin
      eof_t e;
      if (m_cap[i]) begin
        m_cnt[i] = (m_cnt[i] + 1) % 256;
        e.cyc = c + 2; e.err = m_err[i] || (m_y[i] != V); e.cnt = m_cnt[i];
        exp_eof[i].push_back(e);
      end
      m_cap[i] = cap_en; m_x[i] = 0; m_y[i] = 0; m_err[i] = 0; m_half[i] = 0;
    end
  endtask

  // Reset takes effect at edge c: anything predicted from then on never appears.
  task automatic model_reset(input int c);
    for (int i = 0; i < NI; i++) begin
      wr_t  kw[$];
      eof_t ke[$];
      for (int k = 0; k < exp_wr[i].size(); k++)
        if (exp_wr[i][k].cyc < c) kw.push_back(exp_wr[i][k]);
      for (int k = 0; k < exp_eof[i].size(); k++)
        if (exp_eof[i][k].cyc < c) ke.push_back(exp_eof[i][k]);
      exp_wr[i] = kw;
      exp_eof[i] = ke;
      m_cap[i] = 0; m_x[i] = 0; m_y[i] = 0; m_err[i] = 0; m_half[i] = 0; m_cnt[i] = 0;
    end
  endtask

  task automatic send_line(input int n, input logic [7:0] first);
    for (int k = 0; k < n; k++) begin
      @(posedge pclk); #1;
      href = 1'b1; d = 8'(int'(first) + k);
      model_byte(d, cyc);
    end
    @(posedge pclk); #1;
    href = 1'b0; d = 8'h00;
    model_line_end();
    repeat (3) @(posedge pclk);
  endtask

  task automatic pulse_vsync();
    @(posedge pclk); #1;
    vsync = 1'b1;
    model_vsync(cyc);
    repeat (3) @(posedge pclk);
    #1 vsync = 1'b0;
    repeat (3) @(posedge pclk);
  endtask

  function automatic logic [31:0] obs_a(input int i, input int k);
    if (k < obs_wr[i].size()) return 32'(obs_wr[i][k].addr);
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] obs_d(input int i, input int k);
    if (k < obs_wr[i].size()) return 32'(obs_wr[i][k].dout);
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] obs_e(input int i, input int k);
    if (k < obs_eof[i].size()) return {obs_eof[i][k].err, 23'd0, 8'(obs_eof[i][k].cnt)};
    return 32'hDEAD_BEEF;
  endfunction

  task automatic check_idle_outputs(input int i);
    check("rst_addr", i, 32'(addr_w[i]), 0);
    check("rst_dout", i, 32'(dout_w[i]), 0);
    check("rst_we",   i, 32'(we_w[i]),   0);
    check("rst_eof",  i, 32'(eof_w[i]),  0);
    check("rst_ferr", i, 32'(ferr_w[i]), 0);
    check("rst_fcnt", i, 32'(fcnt_w[i]), 0);
  endtask

  // Cycle-by-cycle comparison of every variant against the model's predictions.
  always @(negedge pclk) begin
    if (cmp_on) begin
      for (int i = 0; i < NI; i++) begin
        logic ew, ee;
        wr_t  w, ow;
        eof_t e, oe;
        ew = 1'b0; ee = 1'b0;
        if (exp_wr[i].size() > 0) ew = (exp_wr[i][0].cyc <= cyc);
        if (exp_eof[i].size() > 0) ee = (exp_eof[i][0].cyc <= cyc);
        check("we", i, 32'(we_w[i]), 32'(ew));
        check("eof", i, 32'(eof_w[i]), 32'(ee));
        if (we_w[i] === 1'b1) begin
          ow.cyc = cyc; ow.addr = int'(addr_w[i]); ow.dout = dout_w[i];
          obs_wr[i].push_back(ow);
        end
        if (eof_w[i] === 1'b1) begin
          oe.cyc = cyc; oe.err = ferr_w[i]; oe.cnt = int'(fcnt_w[i]);
          obs_eof[i].push_back(oe);
        end
        if (ew) begin
          w = exp_wr[i].pop_front();
          check("wr_addr", i, 32'(addr_w[i]), 32'(w.addr));
          check("wr_dout", i, 32'(dout_w[i]), 32'(w.dout));
        end
        if (ee) begin
          e = exp_eof[i].pop_front();
          check("frame_err", i, 32'(ferr_w[i]), 32'(e.err));
          check("frame_count", i, 32'(fcnt_w[i]), 32'(e.cnt));
        end
      end
    end
  end

  initial begin
    int base2;
    rst_n = 1'b0; vsync = 1'b0; href = 1'b0; d = 8'h00; cap_en = 1'b0;
    for (int i = 0; i < NI; i++) begin
      m_cap[i] = 0; m_x[i] = 0; m_y[i] = 0; m_err[i] = 0; m_half[i] = 0; m_cnt[i] = 0;
      m_first[i] = 8'h00;
    end
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check_idle_outputs(0);
    cmp_on = 1'b1;
    @(posedge pclk); #1 rst_n = 1'b1;
    repeat (2) @(posedge pclk);

    // Frame A: clean 2x4 frame.
    cap_en = 1'b1;
    pulse_vsync();
    send_line(8, 8'h10);
    send_line(8, 8'h18);
    pulse_vsync();
    check("A_first_addr", 0, obs_a(0, 0), 32'd0);
    check("A_first_dout", 0, obs_d(0, 0), 32'h1011);
    check("A_last_addr",  0, obs_a(0, 7), 32'd7);
    check("A_last_dout",  0, obs_d(0, 7), 32'h1E1F);
    check("A_eof",        0, obs_e(0, 0), {1'b0, 23'd0, 8'd1});
    check("A_swap_dout",  1, obs_d(1, 0), 32'h1110);

    // Frame B: short first line.
    send_line(6, 8'h20);
    send_line(8, 8'h30);
    pulse_vsync();
    check("B_line1_addr", 0, obs_a(0, 11), 32'd4);
    check("B_line1_dout", 0, obs_d(0, 11), 32'h3031);
    check("B_eof",        0, obs_e(0, 1), {1'b1, 23'd0, 8'd2});

    // Frame C: long first line, closed with capture disabled.
    send_line(10, 8'h40);
    send_line(8, 8'h50);
    cap_en = 1'b0;
    pulse_vsync();
    check("C_line0_last", 0, obs_d(0, 18), 32'h4647);
    check("C_line1_addr", 0, obs_a(0, 19), 32'd4);
    check("C_writes",     0, 32'(obs_wr[0].size()), 32'd23);
    check("C_eof",        0, obs_e(0, 2), {1'b1, 23'd0, 8'd3});

    // Frame D: capture disabled, nothing written.
    send_line(8, 8'h60);
    send_line(8, 8'h68);
    pulse_vsync();
    check("D_writes", 0, 32'(obs_wr[0].size()), 32'd23);
    check("D_eofs",   0, 32'(obs_eof[0].size()), 32'd3);

    // Frame E: reset for one cycle in the middle of the first line.
    cap_en = 1'b1;
    pulse_vsync();
    for (int k = 0; k < 3; k++) begin
      @(posedge pclk); #1;
      href = 1'b1; d = 8'(8'h60 + k);
      model_byte(d, cyc);
    end
    @(posedge pclk); #1;
    rst_n = 1'b0;
    model_reset(cyc + 1);
    @(posedge pclk); #1;
    rst_n = 1'b1;
    @(negedge pclk);
    check_idle_outputs(0);
    check("E_rst_we", 2, 32'(we_w[2]), 0);
    for (int k = 3; k < 8; k++) begin
      @(posedge pclk); #1;
      href = 1'b1; d = 8'(8'h60 + k);
      model_byte(d, cyc);
    end
    @(posedge pclk); #1;
    href = 1'b0; d = 8'h00;
    model_line_end();
    repeat (3) @(posedge pclk);
    send_line(8, 8'h70);
    check("E_writes", 0, 32'(obs_wr[0].size()), 32'd24);
    check("E_last_dout", 0, obs_d(0, 23), 32'h6061);

    // Frame F: capture resumes after the reset.
    pulse_vsync();
    base2 = obs_wr[2].size();
    send_line(8, 8'hA5);
    send_line(8, 8'hB0);
    pulse_vsync();
    check("F_bpp1_addr", 2, obs_a(2, base2), 32'd0);
    check("F_bpp1_dout", 2, obs_d(2, base2), 32'h00A5);
    check("F_first_dout", 0, obs_d(0, 24), 32'hA5A6);
    check("F_eof", 0, obs_e(0, 3), {1'b0, 23'd0, 8'd1});

    repeat (4) @(posedge pclk);
    for (int i = 0; i < NI; i++) begin
      check("pending_writes", i, 32'(exp_wr[i].size()), 0);
      check("pending_eofs",   i, 32'(exp_eof[i].size()), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cam_capture_stream.md
Name: cam_capture_stream

Overview:
- Parametrised successor to the team's fixed 640x480 RGB565 camera capture front end. Sits between the DVP camera pins (pclk domain) and the frame buffer write port.
- Assembles 1- or 2-byte pixels gated by HREF and computes line-based frame-buffer addresses.
- Checks frame geometry, reports errors and counts frames.
- An enable input is honoured only at frame boundaries, so frames are never captured partially.

Parameters:
- H_ACTIVE, 640, pixels per line written to the buffer
- V_ACTIVE, 480, lines per frame written to the buffer
- BPP, 2, bytes per pixel (1 or 2 only)
- ADDR_W, 19, frame-buffer address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE
- SWAP_BYTES, 0, 0: first byte is dout[15:8]; 1: first byte is dout[7:0] (BPP=2 only)

Ports:
- pclk  in  1  camera pixel clock; the only clock
- rst_n  in  1  synchronous active-low reset
- vsync  in  1  frame sync; rising edge marks frame start
- href  in  1  line valid; data bytes are valid while high
- d  in  8  camera data byte
- cap_en  in  1  capture enable, sampled only at vsync rising edge
- addr  out  ADDR_W  write address, equal to line_base + x
- dout  out  16  pixel data; BPP=1 gives {8'h00, byte}
- we  out  1  one-cycle write strobe
- end_of_frame  out  1  one-cycle pulse when a captured frame closes
- frame_err  out  1  geometry error flag, valid only while end_of_frame=1
- frame_count  out  8  count of closed frames; wraps 255->0

Behaviour:
- Inputs: vsync, href and d are each registered once (vs_r1/href_r1/d_r). Edges are detected with a second stage (vs_r2/href_r2).
- All outputs are registered. Reset values: addr=0, dout=0, we=0, end_of_frame=0, frame_err=0, frame_count=0. Internal counters reset to 0 and the FSM resets to IDLE.
- Reset asserted mid-frame: abandon the frame, no end_of_frame pulse, and wait for the next vsync rise.
- FSM has two states, IDLE and FRAME.
  - IDLE: on vsync rise with cap_en=1, go to FRAME. x, y, line_base, addr and byte phase clear to 0. No end_of_frame pulse.
  - FRAME: on vsync rise, pulse end_of_frame and frame_err, increment frame_count, then re-evaluate cap_en. cap_en=1 stays in FRAME with counters cleared; cap_en=0 goes to IDLE.
- Pixel assembly (FRAME, href_r1=1): the byte phase toggles on each byte.
  - BPP=2: phase 0 latches the byte. Phase 1 forms the pixel as {first, second}, or {second, first} when SWAP_BYTES=1.
  - BPP=1: every byte is a pixel.
  - Byte phase clears on href rising edge.
- Write: on pixel completion, if x<H_ACTIVE and y<V_ACTIVE, then we=1 on the next cycle with addr=line_base+x and dout=pixel. x increments on every completed pixel, saturating at H_ACTIVE+1. Latency is 2 pclk edges from a byte on d to we for the pixel it completes.
- Line end (href falling edge, FRAME): if x!=0, then y increments (saturating at V_ACTIVE+1), line_base += H_ACTIVE, and x clears. A line with x!=H_ACTIVE sets the internal err_latch. A trailing odd byte at phase 1 (BPP=2) also sets err_latch.
- Frame check at close: frame_err = err_latch OR (y!=V_ACTIVE). err_latch clears at frame start.
- Extra pixels or lines beyond the window are never written; addr never exceeds H_ACTIVE*V_ACTIVE-1.
- Simultaneous vsync rise and href fall: frame close takes priority, and the pending line end is discarded.
- href rising edge while in IDLE has no effect.

Optional Feature:
- CAP_DECIMATE_EN: adds input port decim (1 bit), sampled at frame start.
- decim=1: write only pixels with even x on lines with even y. Address is (y>>1)*(H_ACTIVE/2)+(x>>1). Geometry checks still use raw counts.
- decim=0, or macro undefined: full-resolution behaviour above. With the macro undefined, the decim port does not exist.

Test Plan (bench uses H_ACTIVE=4, V_ACTIVE=2, BPP=2, ADDR_W=3 unless stated):
- Reset, then vsync rise with cap_en=1, then 2 lines of 8 bytes 0x10..0x1F -> 8 writes at addr 0..7 with dout 0x1011, 0x1213 ... 0x1E1F. Next vsync rise gives end_of_frame=1, frame_err=0, frame_count=1.
- Same frame with SWAP_BYTES=1 -> first write dout=0x1110 at addr 0.
- Line 0 carries 6 bytes (3 pixels) -> line 1 still starts at addr 4. frame_err=1 at close.
- Line 0 carries 10 bytes -> only 4 writes for that line. frame_err=1. No addr >= 8.
- cap_en=0 at a vsync rise mid-stream -> close pulse for the current frame, then no we and no end_of_frame on later frames until cap_en=1 at a vsync rise.
- rst_n=0 for 1 cycle mid-line -> all outputs 0. The following href bytes cause no we until the next vsync rise. BPP=1 rerun: byte 0xA5 gives dout=0x00A5.
